// File: rtl/pvr_pkg.sv
// Shared PVR core definitions: VRAM bus geometry, requester indices and
// the arbiter state type.
package pvr_pkg;

  localparam int VRAM_AW = 24;
  localparam int VRAM_DW = 32;

  localparam int REQ_RA  = 0;
  localparam int REQ_ISP = 1;
  localparam int REQ_TSP = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/pvr_rr_pick.sv
// Rotating-priority pick: the first asserted request at or after rr_ptr,
// wrapping cyclically, is returned as a one-hot winner.
module pvr_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner
);

  logic [PW:0]   idx_raw;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx_raw = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_raw = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx_raw >= (PW+1)'(NREQ)) begin
        idx_raw = idx_raw - (PW+1)'(NREQ);
      end
      idx = idx_raw[PW-1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pvr_vram_arbiter.sv
// Shares the single PVR VRAM port between the core requesters with
// round-robin arbitration, optional burst locking and read-return routing.
module pvr_vram_arbiter
  import pvr_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int RD_LAT   = 2,
  parameter int LOCK_MAX = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         we,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*VRAM_AW-1:0] addr,
  input  logic [NREQ*VRAM_DW-1:0] wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rvalid,
  output logic [VRAM_DW-1:0]      rdata,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [VRAM_AW-1:0]      mem_addr,
  output logic [VRAM_DW-1:0]      mem_wdata,
  input  logic                    mem_wait,
  input  logic [VRAM_DW-1:0]      mem_din
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NREQ-1:0] pick;
  logic [PW-1:0]   gnt_id;
  logic [PW-1:0]   mem_id_q;
  logic            issue_ok;
  logic            gnt_any;

  logic [RD_LAT-1:0] pipe_v;
  logic [PW-1:0]     pipe_id [RD_LAT];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(NREQ - 1)) ? '0 : v + PW'(1);
  endfunction

  pvr_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick)
  );

  // A beat stalled by the VRAM must stay on the bus, so nothing new may issue.
  assign issue_ok = !(mem_wait && (mem_rd || mem_wr));
  assign gnt_any  = |gnt;

  always_comb begin
    gnt = '0;
    if (issue_ok) begin
      if (state_q == ARB_LOCKED) begin
        gnt[owner_q] = req[owner_q];
      end else begin
        gnt = pick;
      end
    end
  end

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_id = PW'(i);
      end
    end
  end

  // lock_cnt counts beats already granted in the burst, so the grant seen
  // with lock_cnt == LOCK_MAX-1 is the last one before forced release.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt_any) begin
      if (state_q == ARB_IDLE) begin
        if (lock[gnt_id] && (LOCK_MAX > 1)) begin
          state_d    = ARB_LOCKED;
          owner_d    = gnt_id;
          lock_cnt_d = CW'(1);
        end else begin
          rr_ptr_d = wrap_inc(gnt_id);
        end
      end else if (!lock[owner_q] || (lock_cnt_q == CW'(LOCK_MAX - 1))) begin
        state_d    = ARB_IDLE;
        rr_ptr_d   = wrap_inc(owner_q);
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= PW'(REQ_RA);
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_id_q  <= '0;
    end else if (gnt_any) begin
      mem_rd    <= !we[gnt_id];
      mem_wr    <= we[gnt_id];
      mem_addr  <= addr[gnt_id*VRAM_AW +: VRAM_AW];
      mem_wdata <= wdata[gnt_id*VRAM_DW +: VRAM_DW];
      mem_id_q  <= gnt_id;
    end else if (issue_ok) begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
    end
  end

  // The VRAM returns data a fixed RD_LAT cycles after acceptance, so the
  // requester id simply rides a shift pipe that never stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_v <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_id[s] <= '0;
      end
    end else begin
      pipe_v[0]  <= mem_rd && !mem_wait;
      pipe_id[0] <= mem_id_q;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_v[s]  <= pipe_v[s-1];
        pipe_id[s] <= pipe_id[s-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (pipe_v[RD_LAT-1]) begin
        rvalid[pipe_id[RD_LAT-1]] <= 1'b1;
        rdata                     <= mem_din;
      end
    end
  end

endmodule

// File: tb/tb_pvr_vram_arbiter.sv
// Self-checking bench for pvr_vram_arbiter: directed vector table, hand
// sequences for stalls/reset, and randomized traffic against a cycle model.
module tb_pvr_vram_arbiter;
  import pvr_pkg::*;

  localparam int NREQ     = 3;
  localparam int RD_LAT   = 2;
  localparam int LOCK_MAX = 8;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req, we, lock;
  logic [NREQ*VRAM_AW-1:0] addr;
  logic [NREQ*VRAM_DW-1:0] wdata;
  logic [NREQ-1:0]         gnt, rvalid;
  logic [VRAM_DW-1:0]      rdata;
  logic                    mem_rd, mem_wr;
  logic [VRAM_AW-1:0]      mem_addr;
  logic [VRAM_DW-1:0]      mem_wdata;
  logic                    mem_wait;
  logic [VRAM_DW-1:0]      mem_din;

  pvr_vram_arbiter #(
    .NREQ     (NREQ),
    .RD_LAT   (RD_LAT),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wait  (mem_wait),
    .mem_din   (mem_din)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: arbitration bookkeeping in plain integers plus a
  // queue of outstanding reads tagged with the cycle their strobe is due.
  typedef struct {
    int due;
    int id;
  } ret_t;

  int              m_ptr, m_owner, m_cnt, m_id;
  logic            m_rd, m_wr;
  logic [23:0]     m_addr;
  logic [31:0]     m_wdata, m_rdata;
  logic [2:0]      m_rvalid, m_gnt;
  ret_t            m_ret [$];

  typedef struct {
    logic [2:0] req;
    logic [2:0] we;
    logic [2:0] lock;
    logic       mw;
    logic [2:0] exp_gnt;
    logic       exp_rd;
    logic       exp_wr;
  } vec_t;

  vec_t       tbl [21];
  logic [2:0] pend, pwe, plk;
  int         cnt0, cnt2, cnt_any;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_cnt = 0; m_id = 0;
    m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    m_rdata = '0; m_rvalid = '0; m_gnt = '0;
    m_ret.delete();
  endtask

  task automatic model_step();
    bit   stalled, hit;
    int   g;
    ret_t r;
    stalled = mem_wait && (m_rd || m_wr);
    g = -1;
    if (!stalled) begin
      if (m_owner >= 0) begin
        if (req[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
    end
    m_gnt = (g >= 0) ? 3'(1 << g) : 3'b000;

    check_output("gnt", 64'(gnt), 64'(m_gnt));
    check_output("mem_rd", 64'(mem_rd), 64'(m_rd));
    check_output("mem_wr", 64'(mem_wr), 64'(m_wr));
    check_output("mem_addr", 64'(mem_addr), 64'(m_addr));
    check_output("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    check_output("rvalid", 64'(rvalid), 64'(m_rvalid));
    check_output("rdata", 64'(rdata), 64'(m_rdata));

    if (m_rd && !mem_wait) m_ret.push_back('{due: cyc + RD_LAT + 1, id: m_id});
    hit = 1'b0;
    r   = '{due: 0, id: 0};
    if (m_ret.size() > 0 && m_ret[0].due == cyc + 1) begin
      r   = m_ret.pop_front();
      hit = 1'b1;
    end
    m_rvalid = hit ? 3'(1 << r.id) : 3'b000;
    if (hit) m_rdata = mem_din;

    if (g >= 0) begin
      m_rd    = !we[g];
      m_wr    = we[g];
      m_addr  = addr[g*24 +: 24];
      m_wdata = wdata[g*32 +: 32];
      m_id    = g;
      if (m_owner < 0) begin
        if (lock[g]) begin
          m_owner = g;
          m_cnt   = 1;
        end else begin
          m_ptr = (g + 1) % NREQ;
        end
      end else begin
        m_cnt++;
        if (!lock[g] || m_cnt >= LOCK_MAX) begin
          m_owner = -1;
          m_cnt   = 0;
          m_ptr   = (g + 1) % NREQ;
        end
      end
    end else if (!stalled) begin
      m_rd = 1'b0;
      m_wr = 1'b0;
    end
    cyc++;
  endtask

  // Drives one cycle's inputs and waits to the sampling edge; the caller may
  // add directed checks before finish_cycle runs the model.
  task automatic apply_stimulus(input logic [2:0] r, input logic [2:0] w,
                                input logic [2:0] l, input logic mw);
    req      = r;
    we       = w;
    lock     = l;
    mem_wait = mw;
    mem_din  = $urandom();
    @(negedge clock);
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(3'b000, 3'b000, 3'b000, 1'b0);
      finish_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Round robin with all three requesting.
    for (int i = 0; i < 6; i++) begin
      tbl[i] = '{3'b111, 3'b000, 3'b000, 1'b0, 3'(1 << (i % 3)), (i != 0), 1'b0};
    end
    // Requester 1 locked against contention: 8 beats, release, 2, 0, relock.
    for (int i = 6; i < 14; i++) begin
      tbl[i] = '{3'b111, 3'b000, 3'b010, 1'b0, 3'b010, (i != 6), 1'b0};
    end
    tbl[14] = '{3'b111, 3'b000, 3'b010, 1'b0, 3'b100, 1'b1, 1'b0};
    tbl[15] = '{3'b111, 3'b000, 3'b010, 1'b0, 3'b001, 1'b1, 1'b0};
    tbl[16] = '{3'b111, 3'b000, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0};
    tbl[17] = '{3'b111, 3'b000, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0};
    tbl[18] = '{3'b111, 3'b000, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0};
    tbl[19] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[20] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};

    reset    = 1'b1;
    req      = '0;
    we       = '0;
    lock     = '0;
    mem_wait = 1'b0;
    mem_din  = '0;
    addr     = {24'h000200, 24'h001000, 24'h000100};
    wdata    = {32'h55AA55AA, 32'h11112222, 32'h33334444};
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_mem_rd", 64'(mem_rd), 64'd0);
    check_output("reset_mem_wr", 64'(mem_wr), 64'd0);
    check_output("reset_mem_addr", 64'(mem_addr), 64'd0);
    check_output("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    check_output("reset_rvalid", 64'(rvalid), 64'd0);
    check_output("reset_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    idle(2);

    $display("[TB] round robin table");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i].req, tbl[i].we, tbl[i].lock, tbl[i].mw);
      check_output($sformatf("tbl_gnt[%0d]", i), 64'(gnt), 64'(tbl[i].exp_gnt));
      check_output($sformatf("tbl_rd[%0d]", i), 64'(mem_rd), 64'(tbl[i].exp_rd));
      check_output($sformatf("tbl_wr[%0d]", i), 64'(mem_wr), 64'(tbl[i].exp_wr));
      finish_cycle();
    end
    idle(3);

    $display("[TB] single read latency");
    for (int c = 0; c < 5; c++) begin
      apply_stimulus((c == 0) ? 3'b001 : 3'b000, 3'b000, 3'b000, 1'b0);
      if (c == 3) mem_din = 32'hDEADBEEF;
      if (c == 0) check_output("rd1_gnt", 64'(gnt), 64'h1);
      if (c == 1) begin
        check_output("rd1_mem_rd", 64'(mem_rd), 64'h1);
        check_output("rd1_mem_addr", 64'(mem_addr), 64'h100);
      end
      if (c == 2) check_output("rd1_mem_rd_drop", 64'(mem_rd), 64'h0);
      if (c == 3) check_output("rd1_rvalid_early", 64'(rvalid), 64'h0);
      if (c == 4) begin
        check_output("rd1_rvalid", 64'(rvalid), 64'h1);
        check_output("rd1_rdata", 64'(rdata), 64'hDEADBEEF);
      end
      finish_cycle();
    end

    $display("[TB] lock table");
    for (int i = 6; i < 21; i++) begin
      apply_stimulus(tbl[i].req, tbl[i].we, tbl[i].lock, tbl[i].mw);
      check_output($sformatf("tbl_gnt[%0d]", i), 64'(gnt), 64'(tbl[i].exp_gnt));
      check_output($sformatf("tbl_rd[%0d]", i), 64'(mem_rd), 64'(tbl[i].exp_rd));
      check_output($sformatf("tbl_wr[%0d]", i), 64'(mem_wr), 64'(tbl[i].exp_wr));
      finish_cycle();
    end
    idle(4);

    $display("[TB] stall during read stream");
    cnt0 = 0;
    for (int c = 0; c < 12; c++) begin
      apply_stimulus((c <= 5) ? 3'b001 : 3'b000, 3'b000, 3'b000, (c >= 2 && c <= 4));
      if (c >= 2 && c <= 4) begin
        check_output($sformatf("stall_gnt[%0d]", c), 64'(gnt), 64'h0);
        check_output($sformatf("stall_rd[%0d]", c), 64'(mem_rd), 64'h1);
        check_output($sformatf("stall_addr[%0d]", c), 64'(mem_addr), 64'h100);
      end
      if (c == 5) check_output("stall_resume_gnt", 64'(gnt), 64'h1);
      if (rvalid[0]) cnt0++;
      finish_cycle();
    end
    check_output("stall_rvalid_count", 64'(cnt0), 64'd3);

    $display("[TB] write/read interleave");
    addr[0*24 +: 24] = 24'h000204;
    cnt2 = 0;
    for (int c = 0; c < 8; c++) begin
      apply_stimulus((c == 0) ? 3'b101 : (c == 1) ? 3'b001 : 3'b000,
                     (c == 0) ? 3'b100 : 3'b000, 3'b000, 1'b0);
      if (c == 0) check_output("wr_gnt", 64'(gnt), 64'h4);
      if (c == 1) begin
        check_output("wr_mem_wr", 64'(mem_wr), 64'h1);
        check_output("wr_mem_rd", 64'(mem_rd), 64'h0);
        check_output("wr_addr", 64'(mem_addr), 64'h200);
        check_output("wr_wdata", 64'(mem_wdata), 64'h55AA55AA);
      end
      if (c == 2) begin
        check_output("rd_after_wr_rd", 64'(mem_rd), 64'h1);
        check_output("rd_after_wr_wr", 64'(mem_wr), 64'h0);
        check_output("rd_after_wr_addr", 64'(mem_addr), 64'h204);
      end
      if (c == 5) check_output("rd_after_wr_rvalid", 64'(rvalid), 64'h1);
      if (rvalid[2]) cnt2++;
      finish_cycle();
    end
    check_output("write_no_rvalid", 64'(cnt2), 64'd0);

    $display("[TB] reset with reads in flight");
    for (int c = 0; c < 3; c++) begin
      apply_stimulus((c == 0) ? 3'b011 : (c == 1) ? 3'b001 : 3'b000, 3'b000, 3'b000, 1'b0);
      finish_cycle();
    end
    req   = 3'b000;
    reset = 1'b1;
    #1;
    check_output("rst_mem_rd", 64'(mem_rd), 64'd0);
    check_output("rst_mem_wr", 64'(mem_wr), 64'd0);
    check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_output("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check_output("rst_rvalid", 64'(rvalid), 64'd0);
    check_output("rst_rdata", 64'(rdata), 64'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    cnt_any = 0;
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(3'b000, 3'b000, 3'b000, 1'b0);
      if (rvalid != 3'b000) cnt_any++;
      finish_cycle();
    end
    check_output("post_reset_rvalid_count", 64'(cnt_any), 64'd0);
    apply_stimulus(3'b111, 3'b000, 3'b000, 1'b0);
    check_output("post_reset_tie_gnt", 64'(gnt), 64'h1);
    finish_cycle();
    idle(4);

    $display("[TB] randomized traffic");
    pend = '0;
    pwe  = '0;
    plk  = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]            = 1'b1;
          pwe[i]             = 1'($urandom_range(0, 1));
          plk[i]             = ($urandom_range(0, 3) == 0);
          addr[i*24 +: 24]   = 24'($urandom());
          wdata[i*32 +: 32]  = $urandom();
        end
      end
      apply_stimulus(pend, pwe, plk, ($urandom_range(0, 3) == 0));
      finish_cycle();
      pend = pend & ~m_gnt;
    end
    plk = '0;
    for (int n = 0; n < 40; n++) begin
      apply_stimulus(pend, pwe, plk, 1'b0);
      finish_cycle();
      pend = pend & ~m_gnt;
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
